// File: rtl/core_pkg.sv
// Shared core types: the fetch/decode entry layout and the canonical NOP encoding.
package core_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
   } fetch_entry_t;
endpackage

// File: rtl/fb_storage.sv
// Entry array for the fetch buffer: one synchronous write port, one asynchronous read port.
module fb_storage
   import core_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         wrEn,
   input  logic [AW-1:0] wrAddr,
   input  fetch_entry_t wrData,
   input  logic [AW-1:0] rdAddr,
   output fetch_entry_t rdData
);

   fetch_entry_t entries [DEPTH];

   // One register per slot so each slot has a single driver; contents are never reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : gSlot
         fetch_entry_t entryReg;

         always_ff @(posedge clk) begin
            if (wrEn && (wrAddr == AW'(gi))) begin
               entryReg <= wrData;
            end
         end

         assign entries[gi] = entryReg;
      end
   endgenerate

   assign rdData = entries[rdAddr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue between fetch and decode; shows a NOP bubble when empty
// and drops everything on a taken-branch flush.
module fetch_buffer
   import core_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         FetchValid_i,
   input  logic [DATA_WIDTH-1:0]        InstrF_i,
   input  logic [DATA_WIDTH-1:0]        PCF_i,
   input  logic [DATA_WIDTH-1:0]        PCPlus4F_i,
   output logic                         FetchReady_o,
   input  logic                         StallD_i,
   input  logic                         FlushD_i,
   output logic [DATA_WIDTH-1:0]        InstrD_o,
   output logic [DATA_WIDTH-1:0]        PCD_o,
   output logic [DATA_WIDTH-1:0]        PCPlus4D_o,
   output logic                         ValidD_o,
   output logic [$clog2(DEPTH+1)-1:0]   Count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0] wrPtrReg, wrPtrNext;
   logic [AW-1:0] rdPtrReg, rdPtrNext;
   logic [CW-1:0] countReg, countNext;
   logic          push, pop;
   fetch_entry_t  wrEntry, headEntry;

   // Ready and valid come only from registered occupancy: a pop never frees a slot in the same cycle.
   assign FetchReady_o = (countReg != CW'(DEPTH));
   assign ValidD_o     = (countReg != '0);
   assign Count_o      = countReg;

   assign push = FetchValid_i & FetchReady_o & ~FlushD_i;
   assign pop  = ValidD_o & ~StallD_i & ~FlushD_i;

   always_comb begin
      wrPtrNext = wrPtrReg;
      rdPtrNext = rdPtrReg;
      countNext = countReg;
      if (FlushD_i) begin
         wrPtrNext = '0;
         rdPtrNext = '0;
         countNext = '0;
      end else begin
         if (push) wrPtrNext = wrPtrReg + AW'(1);
         if (pop)  rdPtrNext = rdPtrReg + AW'(1);
         if (push && !pop)      countNext = countReg + CW'(1);
         else if (pop && !push) countNext = countReg - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtrReg <= '0;
         rdPtrReg <= '0;
         countReg <= '0;
      end else begin
         wrPtrReg <= wrPtrNext;
         rdPtrReg <= rdPtrNext;
         countReg <= countNext;
      end
   end

   assign wrEntry.instr    = InstrF_i;
   assign wrEntry.pc       = PCF_i;
   assign wrEntry.pc_plus4 = PCPlus4F_i;

   fb_storage #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) uStorage (
      .clk    (clk),
      .wrEn   (push),
      .wrAddr (wrPtrReg),
      .wrData (wrEntry),
      .rdAddr (rdPtrReg),
      .rdData (headEntry)
   );

   // Empty buffer presents a bubble so decode never sees stale slot contents.
   assign InstrD_o   = ValidD_o ? headEntry.instr    : NOP_INSTR;
   assign PCD_o      = ValidD_o ? headEntry.pc       : '0;
   assign PCPlus4D_o = ValidD_o ? headEntry.pc_plus4 : '0;

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction prefetch queue between the fetch stage and the decode stage of the pipelined core. It decouples the instruction-memory read from decode stalls by holding up to DEPTH fetched instructions with their PC and PC+4. It presents the oldest instruction to decode, or a NOP bubble when empty, and discards all contents on a taken branch/jump flush.

## Interface
- DATA_WIDTH, 32: width of instruction, PC and PC+4 fields
- DEPTH, 4: number of entries; power of two, ≥ 2

Clock and reset:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high

Fetch side:
- FetchValid_i  in  1  fetch presents an instruction this cycle
- InstrF_i  in  DATA_WIDTH  fetched instruction
- PCF_i  in  DATA_WIDTH  PC of fetched instruction
- PCPlus4F_i  in  DATA_WIDTH  PC+4 of fetched instruction
- FetchReady_o  out  1  buffer accepts a push this cycle; equals (Count_o != DEPTH)

Decode side and control:
- StallD_i  in  1  decode holds; no pop this cycle
- FlushD_i  in  1  taken branch/jump (driven from PCSrc); discard all entries
- InstrD_o  out  DATA_WIDTH  head instruction, or NOP when empty
- PCD_o  out  DATA_WIDTH  head PC, or 0 when empty
- PCPlus4D_o  out  DATA_WIDTH  head PC+4, or 0 when empty
- ValidD_o  out  1  head entry valid; equals (Count_o != 0)
- Count_o  out  $clog2(DEPTH+1)  current occupancy

## Operation
- push = FetchValid_i & FetchReady_o & ~FlushD_i; the entry is written at wr_ptr, and wr_ptr increments.
- pop = ValidD_o & ~StallD_i & ~FlushD_i; rd_ptr increments.
- Count next value: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH−1 to 0.
- Flush: next cycle, Count = 0 and rd_ptr = wr_ptr = 0. A push or pop requested in the flush cycle is ignored.
- Priority: rst > FlushD_i > push/pop.
- Full (Count = DEPTH): FetchReady_o = 0. A push is refused even when a pop happens in the same cycle; there is no combinational ready-from-pop path.
- Empty (Count = 0): ValidD_o = 0. Outputs are forced to InstrD_o = 32'h00000013 (addi x0,x0,0), PCD_o = 0 and PCPlus4D_o = 0. StallD_i has no effect.
- There is no bypass from fetch inputs to decode outputs.
- FetchReady_o, ValidD_o and Count_o are derived from registered state only.

## Timing
- Reset values: Count_o = 0, ValidD_o = 0, FetchReady_o = 1, InstrD_o = NOP, PCD_o = 0, PCPlus4D_o = 0.
- Storage array is not reset.
- Push-to-visible latency is 1 cycle. An instruction pushed at edge N appears on the decode outputs after edge N when the buffer was empty.
- Pop takes effect at the edge. The next entry, or the bubble, is visible after that edge.
- Throughput is 1 instruction per cycle when neither side stalls.
- Reset or flush mid-operation discards every entry within one edge. No stale instruction reaches decode afterwards.
- Decode outputs are a combinational read of the head register and are stable for the whole cycle.

## Structure
- Shared package `core_pkg` holds:
  - NOP_INSTR = 32'h00000013
  - a packed struct fetch_entry_t {instr, pc, pc_plus4}, each DATA_WIDTH bits
- One sub-module, `fb_storage`: DEPTH × fetch_entry_t register array with a synchronous write port and an asynchronous read port.
- Pointer, count and flush control live in `fetch_buffer`.

## Test plan
- Reset, then 4 back-to-back pushes (PC 0x00, 0x04, 0x08, 0x0C) with StallD_i = 0 → decode sees the same PCs in order, one per cycle starting 1 cycle after the first push; ValidD_o stays 1 throughout.
- StallD_i = 1 while pushing 5 instructions with DEPTH = 4 → Count_o reaches 4; FetchReady_o = 0 on the 5th; the 5th is not stored; decode holds PC 0x00.
- Full buffer with StallD_i = 0 and FetchValid_i = 1 in the same cycle → pop occurs, push refused, Count_o = 3; the next cycle accepts the push and Count_o = 4.
- 3 entries buffered, FlushD_i = 1 together with FetchValid_i = 1 → next cycle Count_o = 0, ValidD_o = 0, InstrD_o = 32'h00000013; a following push at PC 0x40 is the next decoded PC.
- rst asserted with 2 entries buffered → all outputs at reset values next cycle.
- Run 10 push/pop cycles to force pointer wrap → decoded PC order is preserved.
